bit_serializer: RTL and testbench

Upstream feeder for the serial sequence detectors (Moore/Mealy 1011 family). It accepts parallel words over a valid/ready handshake and buffers them in a small FIFO. It shifts each word out MSB-first, one bit per clock, on `sout`, which drives the detector's `din` directly. Consecutive frames are emitted back-to-back with no idle gap, so detector sequences can span word boundaries.

---
 rtl/bit_serializer.sv | 216 +++++++++++++++++++++
 tb/tb_bit_serializer.sv | 382 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bit_serializer.sv
// bit_serializer: parallel-to-serial feeder for the 1011 sequence detectors.
// Words arrive over a valid/ready handshake, are buffered in a small FIFO and
// shifted out MSB-first on sout, one bit per clock, with consecutive frames
// emitted back-to-back so detector patterns may span word boundaries.
//
// Optional feature: define BIT_SERIALIZER_PARITY_EN to append one trailing
// even-parity bit (^word) to every frame via an extra PARITY state.
//
// Handshake: a word transfers on a rising edge where data_valid && data_ready.
// data_ready depends only on the registered FIFO count, never on data_valid,
// and the source must hold data_in stable while data_valid is high and
// data_ready is low.
//
// The shifter FSM state is held in the enum register `state` (and its next
// value `state_n`) so checkers can bind to it by name.

module bit_serializer #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_in,
  input  logic             data_valid,
  output logic             data_ready,
  output logic             sout,
  output logic             sout_valid,
  output logic             frame_start,
  output logic             busy
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  localparam logic [CW-1:0] FULL   = CW'(DEPTH);
  localparam logic [CW-1:0] ONE_C  = CW'(1);
  localparam logic [AW-1:0] ONE_P  = AW'(1);
  localparam logic [BW-1:0] LAST   = BW'(WIDTH - 1);
  localparam logic [BW-1:0] ONE_B  = BW'(1);

`ifdef BIT_SERIALIZER_PARITY_EN
  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SHIFT  = 2'd1,
    S_PARITY = 2'd2
  } state_t;
`else
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1
  } state_t;
`endif

  // ---------------------------------------------------------------------------
  // FIFO storage and bookkeeping
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic [WIDTH-1:0] head;
  logic             push;
  logic             pop;

  assign data_ready = (count != FULL);
  assign push       = data_valid && data_ready;
  assign head       = mem[rd_ptr];

  // ---------------------------------------------------------------------------
  // Shifter registers
  // ---------------------------------------------------------------------------
  state_t           state;
  state_t           state_n;
  logic [WIDTH-1:0] shreg;
  logic [WIDTH-1:0] shreg_n;
  logic [BW-1:0]    bitcnt;
  logic [BW-1:0]    bitcnt_n;
  logic             sout_n;
  logic             sout_valid_n;
  logic             frame_start_n;
  logic             frame_done;
`ifdef BIT_SERIALIZER_PARITY_EN
  logic             par;
  logic             par_n;
`endif

  assign busy = (count != '0) || (state != S_IDLE);

  // FIFO storage: write the incoming word at the tail on every accepted push.
  always_ff @(posedge clock) begin
    if (push) begin
      mem[wr_ptr] <= data_in;
    end
  end

  // FIFO pointers and occupancy; a simultaneous push and pop keeps count.
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + ONE_P;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + ONE_P;
      end
      case ({push, pop})
        2'b10:   count <= count + ONE_C;
        2'b01:   count <= count - ONE_C;
        default: count <= count;
      endcase
    end
  end

  // Shifter state register: all serial outputs are registered here.
  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= S_IDLE;
      shreg       <= '0;
      bitcnt      <= '0;
      sout        <= 1'b0;
      sout_valid  <= 1'b0;
      frame_start <= 1'b0;
`ifdef BIT_SERIALIZER_PARITY_EN
      par         <= 1'b0;
`endif
    end else begin
      state       <= state_n;
      shreg       <= shreg_n;
      bitcnt      <= bitcnt_n;
      sout        <= sout_n;
      sout_valid  <= sout_valid_n;
      frame_start <= frame_start_n;
`ifdef BIT_SERIALIZER_PARITY_EN
      par         <= par_n;
`endif
    end
  end

  // Shifter next-state logic. IDLE and the end of a frame share one decision:
  // pop the FIFO head (only words already stored, so no bypass) or go idle.
  always_comb begin
    state_n       = state;
    shreg_n       = shreg;
    bitcnt_n      = bitcnt;
    sout_n        = sout;
    sout_valid_n  = sout_valid;
    frame_start_n = frame_start;
    pop           = 1'b0;
    frame_done    = 1'b0;
`ifdef BIT_SERIALIZER_PARITY_EN
    par_n         = par;
`endif

    case (state)
      S_IDLE: begin
        sout_n        = 1'b0;
        sout_valid_n  = 1'b0;
        frame_start_n = 1'b0;
        frame_done    = 1'b1;
      end
      S_SHIFT: begin
        if (bitcnt != '0) begin
          sout_n        = shreg[WIDTH-1];
          shreg_n       = shreg << 1;
          bitcnt_n      = bitcnt - ONE_B;
          frame_start_n = 1'b0;
        end else begin
`ifdef BIT_SERIALIZER_PARITY_EN
          // Last data bit is on sout; follow it with the parity bit.
          state_n       = S_PARITY;
          sout_n        = par;
          frame_start_n = 1'b0;
`else
          frame_done    = 1'b1;
`endif
        end
      end
`ifdef BIT_SERIALIZER_PARITY_EN
      S_PARITY: begin
        frame_done = 1'b1;
      end
`endif
      default: begin
        state_n       = S_IDLE;
        sout_n        = 1'b0;
        sout_valid_n  = 1'b0;
        frame_start_n = 1'b0;
      end
    endcase

    if (frame_done) begin
      if (count != '0) begin
        pop           = 1'b1;
        sout_n        = head[WIDTH-1];
        shreg_n       = head << 1;
        bitcnt_n      = LAST;
        sout_valid_n  = 1'b1;
        frame_start_n = 1'b1;
        state_n       = S_SHIFT;
`ifdef BIT_SERIALIZER_PARITY_EN
        par_n         = ^head;
`endif
      end else begin
        state_n       = S_IDLE;
        sout_n        = 1'b0;
        sout_valid_n  = 1'b0;
        frame_start_n = 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_bit_serializer.sv
// tb_bit_serializer: self-checking bench for bit_serializer. A queue-based
// reference model (FIFO of words, queue of pending serial bits) predicts the
// outputs every cycle; a scoreboard compares reassembled frames with words
// accepted by the handshake.

module tb_bit_serializer;

  localparam int WIDTH = 8;
  localparam int DEPTH = 4;
`ifdef BIT_SERIALIZER_PARITY_EN
  localparam int FRAME = WIDTH + 1;
`else
  localparam int FRAME = WIDTH;
`endif

  logic             clock = 1'b0;
  logic             reset;
  logic [WIDTH-1:0] data_in;
  logic             data_valid;
  logic             data_ready;
  logic             sout;
  logic             sout_valid;
  logic             frame_start;
  logic             busy;

  int errors = 0;
  int checks = 0;

  // model state
  logic [WIDTH-1:0] m_fifo[$];
  bit               m_bits[$];
  bit               m_fs;
  int               edge_no;

  // scoreboard
  logic [FRAME-1:0] exp_q[$];
  logic [FRAME-1:0] got_q[$];
  logic [FRAME-1:0] cur;
  int               ncur;
  bit               stream_q[$];

  // clock / reset block
  always #5 clock = ~clock;

  bit_serializer #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clock       (clock),
    .reset       (reset),
    .data_in     (data_in),
    .data_valid  (data_valid),
    .data_ready  (data_ready),
    .sout        (sout),
    .sout_valid  (sout_valid),
    .frame_start (frame_start),
    .busy        (busy)
  );

  function automatic logic [FRAME-1:0] frame_of(input logic [WIDTH-1:0] w);
`ifdef BIT_SERIALIZER_PARITY_EN
    return {w, ^w};
`else
    return w;
`endif
  endfunction

  // expected {sout, sout_valid, frame_start, busy, data_ready}
  function automatic logic [4:0] exp_out();
    logic b;
    b = (m_bits.size() != 0) ? m_bits[0] : 1'b0;
    return {b, m_bits.size() != 0, m_fs,
            (m_fifo.size() != 0) || (m_bits.size() != 0),
            m_fifo.size() != DEPTH};
  endfunction

  task automatic do_reset(input int n);
    reset      = 1'b1;
    data_valid = 1'b0;
    data_in    = '0;
    repeat (n) @(posedge clock);
    m_fifo.delete();
    m_bits.delete();
    m_fs = 1'b0;
    exp_q.delete();
    got_q.delete();
    stream_q.delete();
    ncur    = 0;
    cur     = '0;
    edge_no = 0;
    #1;
    reset = 1'b0;
  endtask

  // driver: one clock with the given inputs, then advance model and monitor
  task automatic tick(input bit v, input logic [WIDTH-1:0] d);
    bit               acc;
    logic [WIDTH-1:0] w;
    data_valid = v;
    data_in    = d;
    acc = v && (m_fifo.size() != DEPTH);
    @(posedge clock);
    edge_no++;
    if (m_bits.size() > 1) begin
      void'(m_bits.pop_front());
      m_fs = 1'b0;
    end else if (m_fifo.size() != 0) begin
      w = m_fifo.pop_front();
      m_bits.delete();
      for (int i = WIDTH - 1; i >= 0; i--) m_bits.push_back(w[i]);
`ifdef BIT_SERIALIZER_PARITY_EN
      m_bits.push_back(^w);
`endif
      m_fs = 1'b1;
    end else begin
      m_bits.delete();
      m_fs = 1'b0;
    end
    if (acc) begin
      m_fifo.push_back(d);
      exp_q.push_back(frame_of(d));
    end
    #1;
    if (sout_valid) begin
      stream_q.push_back(sout);
      if (frame_start) ncur = 0;
      cur = {cur[FRAME-2:0], sout};
      ncur++;
      if (ncur == FRAME) begin
        got_q.push_back(cur);
        ncur = 0;
      end
    end
  endtask

  task automatic test_reset();
    do_reset(2);
    checks++;
    if ({sout, sout_valid, frame_start, busy, data_ready} !== 5'b00001) begin
      errors++;
      $display("FAIL reset_state got=%b exp=%b",
               {sout, sout_valid, frame_start, busy, data_ready}, 5'b00001);
    end
  endtask

  task automatic test_single_word();
    logic [FRAME-1:0] want;
    do_reset(2);
    tick(1'b1, 8'hB5);
    for (int c = 0; c < FRAME + 4; c++) begin
      tick(1'b0, '0);
      checks++;
      if ({sout, sout_valid, frame_start, busy, data_ready} !== exp_out()) begin
        errors++;
        $display("FAIL single_cycle%0d got=%b exp=%b", c,
                 {sout, sout_valid, frame_start, busy, data_ready}, exp_out());
      end
    end
`ifdef BIT_SERIALIZER_PARITY_EN
    want = {8'hB5, 1'b1};
`else
    want = 8'hB5;
`endif
    checks++;
    if (got_q.size() != 1 || got_q[0] !== want) begin
      errors++;
      $display("FAIL single_frame got_n=%0d got=%h exp=%h", got_q.size(),
               (got_q.size() != 0) ? got_q[0] : '0, want);
    end
  endtask

  task automatic test_back_to_back();
    int hits;
    bit [3:0] win;
    int n;
    do_reset(2);
    tick(1'b1, 8'hBB);
    tick(1'b1, 8'h0B);
    for (int c = 0; c < 2 * FRAME + 4; c++) begin
      tick(1'b0, '0);
      checks++;
      if ({sout, sout_valid, frame_start, busy, data_ready} !== exp_out()) begin
        errors++;
        $display("FAIL b2b_cycle%0d got=%b exp=%b", c,
                 {sout, sout_valid, frame_start, busy, data_ready}, exp_out());
      end
    end
    // non-overlapping 1011 detector over the captured valid bits
    hits = 0;
    win  = '0;
    n    = 0;
    foreach (stream_q[i]) begin
      win = {win[2:0], stream_q[i]};
      n++;
      if (n >= 4 && win == 4'b1011) begin
        hits++;
        n = 0;
      end
    end
    checks++;
    if (stream_q.size() != 2 * FRAME || hits != 3) begin
      errors++;
      $display("FAIL b2b_stream bits=%0d exp_bits=%0d hits=%0d exp_hits=3",
               stream_q.size(), 2 * FRAME, hits);
    end
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (got_q.size() <= i || exp_q.size() <= i || got_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL b2b_frame%0d got_n=%0d exp_n=%0d", i, got_q.size(), exp_q.size());
      end
    end
  endtask

  task automatic test_backpressure();
    logic [WIDTH-1:0] words[6];
    int k;
    int guard;
    for (int i = 0; i < 6; i++) words[i] = WIDTH'(8'h11 * (i + 1));
    do_reset(2);
    k = 0;
    guard = 0;
    while ((k < 6 || m_fifo.size() != 0 || m_bits.size() != 0) && guard < 150) begin
      tick(k < 6, (k < 6) ? words[k] : '0);
      guard++;
      k = exp_q.size();
      checks++;
      if ({sout, sout_valid, frame_start, busy, data_ready} !== exp_out()) begin
        errors++;
        $display("FAIL bp_edge%0d got=%b exp=%b", edge_no,
                 {sout, sout_valid, frame_start, busy, data_ready}, exp_out());
      end
      if (edge_no == 5 || edge_no == 1 + FRAME) begin
        checks++;
        if (data_ready !== 1'b0) begin
          errors++;
          $display("FAIL bp_full_edge%0d ready=%b exp=0", edge_no, data_ready);
        end
      end
      if (edge_no == 2 + FRAME) begin
        checks++;
        if (data_ready !== 1'b1) begin
          errors++;
          $display("FAIL bp_reopen_edge%0d ready=%b exp=1", edge_no, data_ready);
        end
      end
    end
    checks++;
    if (guard >= 150) begin
      errors++;
      $display("FAIL bp_timeout accepted=%0d exp=6", k);
    end
    checks++;
    if (got_q.size() != 6) begin
      errors++;
      $display("FAIL bp_count got=%0d exp=6", got_q.size());
    end
    for (int i = 0; i < 6 && i < got_q.size(); i++) begin
      checks++;
      if (got_q[i] !== frame_of(words[i])) begin
        errors++;
        $display("FAIL bp_order%0d got=%h exp=%h", i, got_q[i], frame_of(words[i]));
      end
    end
  endtask

  task automatic test_reset_mid_frame();
    int guard;
    do_reset(2);
    tick(1'b1, 8'hF0);
    guard = 0;
    while (stream_q.size() < 3 && guard < 20) begin
      tick(1'b0, '0);
      guard++;
    end
    checks++;
    if (stream_q.size() != 3) begin
      errors++;
      $display("FAIL midrst_start bits=%0d exp=3", stream_q.size());
    end
    do_reset(1);
    checks++;
    if ({sout, sout_valid, frame_start, busy, data_ready} !== 5'b00001) begin
      errors++;
      $display("FAIL midrst_state got=%b exp=%b",
               {sout, sout_valid, frame_start, busy, data_ready}, 5'b00001);
    end
    for (int c = 0; c < 15; c++) tick(1'b0, '0);
    checks++;
    if (stream_q.size() != 0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL midrst_residue bits=%0d busy=%b exp=0,0", stream_q.size(), busy);
    end
  endtask

`ifdef BIT_SERIALIZER_PARITY_EN
  task automatic test_parity();
    do_reset(2);
    tick(1'b1, 8'hB5);
    tick(1'b1, 8'h03);
    for (int c = 0; c < 2 * FRAME + 3; c++) tick(1'b0, '0);
    checks++;
    if (got_q.size() != 2 || got_q[0] !== 9'b1011_0101_1 || got_q[1] !== 9'b0000_0011_0) begin
      errors++;
      $display("FAIL parity got_n=%0d f0=%b f1=%b exp=101101011,000000110",
               got_q.size(), (got_q.size() > 0) ? got_q[0] : '0,
               (got_q.size() > 1) ? got_q[1] : '0);
    end
  endtask
`endif

  task automatic test_idle_hold();
    do_reset(2);
    for (int c = 0; c < 20; c++) begin
      tick(1'b0, logic'($urandom_range(0, 1)) ? WIDTH'($urandom) : '0);
      checks++;
      if ({sout, sout_valid, frame_start, busy, data_ready} !== 5'b00001) begin
        errors++;
        $display("FAIL idle_cycle%0d got=%b exp=%b", c,
                 {sout, sout_valid, frame_start, busy, data_ready}, 5'b00001);
      end
    end
  endtask

  task automatic test_random();
    bit               pend;
    logic [WIDTH-1:0] word;
    int               prev;
    int               guard;
    do_reset(2);
    pend = 1'b0;
    word = '0;
    for (int c = 0; c < 400; c++) begin
      if (!pend && $urandom_range(0, 3) != 0) begin
        pend = 1'b1;
        word = WIDTH'($urandom);
      end
      prev = exp_q.size();
      tick(pend, word);
      if (exp_q.size() != prev) pend = 1'b0;
      checks++;
      if ({sout, sout_valid, frame_start, busy, data_ready} !== exp_out()) begin
        errors++;
        $display("FAIL rand_edge%0d got=%b exp=%b", edge_no,
                 {sout, sout_valid, frame_start, busy, data_ready}, exp_out());
      end
    end
    guard = 0;
    while ((m_fifo.size() != 0 || m_bits.size() != 0) && guard < 200) begin
      tick(1'b0, '0);
      guard++;
    end
    checks++;
    if (guard >= 200 || got_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL rand_drain frames=%0d exp=%0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL rand_frame%0d got=%h exp=%h", i, got_q[i], exp_q[i]);
      end
    end
  endtask

  initial begin
    reset      = 1'b1;
    data_valid = 1'b0;
    data_in    = '0;
    test_reset();
    test_single_word();
    test_back_to_back();
    test_backpressure();
    test_reset_mid_frame();
`ifdef BIT_SERIALIZER_PARITY_EN
    test_parity();
`endif
    test_idle_hold();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
